// File: rtl/dmem_arbiter.sv
// Round-robin arbiter letting two requesters share one single-port dmem (1-cycle sync read).
// Define DMEM_ARB_LOCK_EN to add the rN_lock ports and exclusive-ownership locking.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0]    r0_wdata,
  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]    r1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                     r0_lock,
  input  logic                     r1_lock,
`endif
  output logic                     r0_gnt,
  output logic                     r1_gnt,
  output logic                     r0_rvalid,
  output logic [DATA_WIDTH-1:0]    r0_rdata,
  output logic                     r1_rvalid,
  output logic [DATA_WIDTH-1:0]    r1_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_st_t;

  logic [1:0]               req, we, gnt, lock, rvalid;
  logic [ADDRESS_WIDTH-1:0] addr  [2];
  logic [DATA_WIDTH-1:0]    wdata [2];
  logic [DATA_WIDTH-1:0]    rdata [2];
  logic                     last_reg, rsp_vld_reg, rsp_id_reg;
  lock_st_t                 lock_st_reg;
  logic                     accept, win_id;

  assign req      = {r1_req, r0_req};
  assign we       = {r1_we, r0_we};
  assign addr[0]  = r0_addr;
  assign addr[1]  = r1_addr;
  assign wdata[0] = r0_wdata;
  assign wdata[1] = r1_wdata;
`ifdef DMEM_ARB_LOCK_EN
  assign lock     = {r1_lock, r0_lock};
`else
  // Without lock support the lock FSM never leaves UNLOCKED.
  assign lock     = 2'b00;
`endif

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (lock_st_reg)
        LOCKED0: gnt[0] = req[0];
        LOCKED1: gnt[1] = req[1];
        default: begin
          // On a tie the requester that did not win last time goes first.
          if (req[0] && (!req[1] || last_reg)) gnt[0] = 1'b1;
          else if (req[1])                     gnt[1] = 1'b1;
        end
      endcase
    end
  end

  assign accept    = |gnt;
  assign win_id    = gnt[1];
  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign mem_we    = |(gnt & we);
  assign mem_addr  = gnt[1] ? addr[1]  : (gnt[0] ? addr[0]  : '0);
  assign mem_wdata = gnt[1] ? wdata[1] : (gnt[0] ? wdata[0] : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg    <= 1'b1;
      rsp_vld_reg <= 1'b0;
      rsp_id_reg  <= 1'b0;
      lock_st_reg <= UNLOCKED;
    end else begin
      rsp_vld_reg <= accept && !we[win_id];
      if (accept) begin
        last_reg   <= win_id;
        rsp_id_reg <= win_id;
        case (lock_st_reg)
          UNLOCKED: if (lock[win_id]) lock_st_reg <= win_id ? LOCKED1 : LOCKED0;
          // Only the owner can be granted while locked, so win_id is the owner here.
          default:  if (!lock[win_id]) lock_st_reg <= UNLOCKED;
        endcase
      end
    end
  end

  // The dmem read data lands one cycle after acceptance; a reset in that cycle kills it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rvalid[gi] = rsp_vld_reg && !rst && (rsp_id_reg == 1'(gi));
    assign rdata[gi]  = rvalid[gi] ? mem_rdata : '0;
  end

  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_rdata  = rdata[0];
  assign r1_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a rule-level model predicts grants, bus contents and
// read responses; a separate monitor matches responses against the expected-response queue.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 33;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
  logic          r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we;
  logic [DW-1:0] r0_rdata, r1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Attached single-port dmem with registered read.
  logic [DW-1:0] dmem [256];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] ref_mem [256];
  bit            m_last  = 1'b1;
  int            m_owner = -1;
  logic [1:0]    exp_gnt = 2'b00;
  int            checks  = 0;
  int            errors  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides the winner from the arbitration rules each cycle.
  always @(negedge clk) begin : model
    logic [1:0]    rq;
    int            w;
    logic          we_w, lk;
    logic [AW-1:0] a_w;
    logic [DW-1:0] d_w;
    rq = {r1_req, r0_req};
    w  = -1;
    if (!rst) begin
      if (m_owner >= 0) begin
        if (rq[m_owner]) w = m_owner;
      end else if (rq == 2'b11) w = m_last ? 0 : 1;
      else if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
    end
    exp_gnt = (w < 0) ? 2'b00 : 2'(2'b01 << w);
    check("gnt", {r1_gnt, r0_gnt}, exp_gnt);
    if (w < 0) begin
      check("mem_idle", {mem_we, mem_addr, mem_wdata}, '0);
    end else begin
      if (w == 0) begin we_w = r0_we; a_w = r0_addr; d_w = r0_wdata; lk = r0_lock; end
      else        begin we_w = r1_we; a_w = r1_addr; d_w = r1_wdata; lk = r1_lock; end
      check("mem_bus", {mem_we, mem_addr, mem_wdata}, {we_w, a_w, d_w});
      if (we_w) ref_mem[a_w] = d_w;
      else      sb.push_back('{cyc + 1, w[0], ref_mem[a_w]});
      m_last = w[0];
      if (LOCK_EN) begin
        if (m_owner < 0 && lk)        m_owner = w;
        else if (m_owner == w && !lk) m_owner = -1;
      end
    end
    if (rst) begin
      m_last  = 1'b1;
      m_owner = -1;
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a read response.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst) begin
      check("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
      sb.delete();
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid cycle %0d: got none expected port %0d due %0d",
                 cyc, sb[0].port, sb[0].due);
        void'(sb.pop_front());
      end
      if (r0_rvalid || r1_rvalid) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid cycle %0d: got %b expected 00", cyc, {r1_rvalid, r0_rvalid});
        end else begin
          e = sb.pop_front();
          check("rvalid_port", {r1_rvalid, r0_rvalid}, e.port ? 2'b10 : 2'b01);
          check("rdata", e.port ? r1_rdata : r0_rdata, e.data);
        end
      end
    end
    check("rdata_zero", {r0_rvalid ? '0 : r0_rdata, r1_rvalid ? '0 : r1_rdata}, '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic q, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic l);
    r0_req = q; r0_we = w; r0_addr = a; r0_wdata = d; r0_lock = l;
  endtask

  task automatic set1(input logic q, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic l);
    r1_req = q; r1_we = w; r1_addr = a; r1_wdata = d; r1_lock = l;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    // Reset held three cycles while both ports request.
    rst = 1'b1;
    set0(1'b1, 1'b0, 8'h00, '0, 1'b0);
    set1(1'b1, 1'b0, 8'h00, '0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    // Write from r0, then read the same word back through r1.
    set0(1'b1, 1'b1, 8'h10, 33'h1_2345_6789, 1'b0);
    set1(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
    set0(1'b0, 1'b0, 8'h00, '0, 1'b0);
    set1(1'b1, 1'b0, 8'h10, '0, 1'b0);
    step();
    set1(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
    // Continuous reads from both ports alternate.
    set0(1'b1, 1'b0, 8'h10, '0, 1'b0);
    set1(1'b1, 1'b0, 8'h11, '0, 1'b0);
    repeat (8) step();
    // Read accepted, then reset the next cycle: response dropped, r0 wins the next tie.
    set1(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
    set0(1'b0, 1'b0, 8'h00, '0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set0(1'b1, 1'b0, 8'h10, '0, 1'b0);
    set1(1'b1, 1'b0, 8'h11, '0, 1'b0);
    step();
    set0(1'b0, 1'b0, 8'h00, '0, 1'b0);
    set1(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
    // Single write: no response, mem_we for one cycle only.
    set0(1'b1, 1'b1, 8'h20, 33'h0_DEAD_BEEF, 1'b0);
    step();
    set0(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
`ifdef DMEM_ARB_LOCK_EN
    // r1 locks with a read, keeps the lock, then unlocks with a write; r0 waits throughout.
    set0(1'b1, 1'b0, 8'h30, '0, 1'b0);
    set1(1'b1, 1'b0, 8'h10, '0, 1'b1);
    step();
    set1(1'b1, 1'b0, 8'h11, '0, 1'b1);
    step();
    set1(1'b1, 1'b1, 8'h12, rand_word(), 1'b0);
    step();
    set1(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
    set0(1'b0, 1'b0, 8'h00, '0, 1'b0);
    step();
`endif
    // Random traffic; an ungranted request keeps its fields stable.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!r0_req || exp_gnt[0])
        set0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 15)), rand_word(), 1'($urandom_range(0, 3) == 0));
      if (!r1_req || exp_gnt[1])
        set1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 15)), rand_word(), 1'($urandom_range(0, 3) == 0));
      step();
    end
    rst = 1'b0;
    set0(1'b0, 1'b0, 8'h00, '0, 1'b0);
    set1(1'b0, 1'b0, 8'h00, '0, 1'b0);
    repeat (3) step();
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
